// File: rtl/cpu_job_dispatcher.sv
// Job dispatcher for simple_cpu_top: queues operand pairs, launches
// one CPU job at a time and returns result, timeout flag and cycle count.
module cpu_job_dispatcher #(
  parameter int BIT_WIDTH      = 16,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_WIDTH-1:0] in_a,
  input  logic [BIT_WIDTH-1:0] in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] out_result,
  output logic                 out_timeout,
  output logic [15:0]          out_cycles,
  output logic                 cpu_start,
  output logic [BIT_WIDTH-1:0] cpu_operand_a,
  output logic [BIT_WIDTH-1:0] cpu_operand_b,
  input  logic [BIT_WIDTH-1:0] cpu_result,
  input  logic                 cpu_done,
  output logic                 busy,
  output logic [15:0]          jobs_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [16:0] TMO = 17'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state;

  logic [BIT_WIDTH-1:0] fifo_a [FIFO_DEPTH];
  logic [BIT_WIDTH-1:0] fifo_b [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          count;

  logic        fifo_empty;
  logic        fifo_full;
  logic        push;
  logic        pop;
  logic        done_q;
  logic        done_rise;
  logic [15:0] cnt;
  logic [16:0] cnt_inc;
  logic        tmo_hit;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);
  assign in_ready   = !fifo_full;
  assign push       = in_valid && in_ready;
  assign pop        = (state == S_IDLE) && !fifo_empty;
  assign done_rise  = cpu_done && !done_q;
  assign cnt_inc    = {1'b0, cnt} + 17'd1;
  assign tmo_hit    = (cnt_inc == TMO);
  assign busy       = (state != S_IDLE) || !fifo_empty;

  // Storage is not reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a[wr_ptr] <= in_a;
      fifo_b[wr_ptr] <= in_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      done_q        <= 1'b0;
      cnt           <= '0;
      cpu_start     <= 1'b0;
      cpu_operand_a <= '0;
      cpu_operand_b <= '0;
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_timeout   <= 1'b0;
      out_cycles    <= '0;
      jobs_done     <= '0;
    end else begin
      done_q    <= cpu_done;
      cpu_start <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            cpu_operand_a <= fifo_a[rd_ptr];
            cpu_operand_b <= fifo_b[rd_ptr];
            cpu_start     <= 1'b1;
            state         <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt != 16'hFFFF) cnt <= cnt_inc[15:0];
          // a completion in the timeout cycle still counts as done
          if (done_rise) begin
            out_result  <= cpu_result;
            out_timeout <= 1'b0;
            out_cycles  <= cnt_inc[15:0];
            out_valid   <= 1'b1;
            state       <= S_RESP;
          end else if (tmo_hit) begin
            out_result  <= '0;
            out_timeout <= 1'b1;
            out_cycles  <= TMO[15:0];
            out_valid   <= 1'b1;
            state       <= S_RESP;
          end
        end
        S_RESP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            jobs_done <= jobs_done + 16'd1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_job_dispatcher.sv
// Directed bench for cpu_job_dispatcher: two instances (default and
// 16-cycle timeout), each driven by a small behavioural CPU model.
module tb_cpu_job_dispatcher;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid [2];
  logic        in_ready [2];
  logic [15:0] in_a [2];
  logic [15:0] in_b [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [15:0] out_result [2];
  logic        out_timeout [2];
  logic [15:0] out_cycles [2];
  logic        cpu_start [2];
  logic [15:0] cpu_operand_a [2];
  logic [15:0] cpu_operand_b [2];
  logic [15:0] cpu_result [2];
  logic        cpu_done [2];
  logic        busy [2];
  logic [15:0] jobs_done [2];

  int          n_chk = 0;
  int          n_pass = 0;
  int          lat [2];
  logic [15:0] mcnt [2];
  logic [15:0] got_q [$];

  cpu_job_dispatcher u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_a(in_a[0]), .in_b(in_b[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_result(out_result[0]), .out_timeout(out_timeout[0]),
    .out_cycles(out_cycles[0]), .cpu_start(cpu_start[0]),
    .cpu_operand_a(cpu_operand_a[0]),
    .cpu_operand_b(cpu_operand_b[0]),
    .cpu_result(cpu_result[0]), .cpu_done(cpu_done[0]),
    .busy(busy[0]), .jobs_done(jobs_done[0])
  );

  cpu_job_dispatcher #(.TIMEOUT_CYCLES(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_a(in_a[1]), .in_b(in_b[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_result(out_result[1]), .out_timeout(out_timeout[1]),
    .out_cycles(out_cycles[1]), .cpu_start(cpu_start[1]),
    .cpu_operand_a(cpu_operand_a[1]),
    .cpu_operand_b(cpu_operand_b[1]),
    .cpu_result(cpu_result[1]), .cpu_done(cpu_done[1]),
    .busy(busy[1]), .jobs_done(jobs_done[1])
  );

  // CPU model: result a+b, done high from the lat-th WAIT cycle on
  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        mcnt[i]       <= '0;
        cpu_result[i] <= '0;
      end else if (cpu_start[i]) begin
        mcnt[i]       <= 16'd1;
        cpu_result[i] <= cpu_operand_a[i] + cpu_operand_b[i];
      end else if (mcnt[i] != 0 && int'(mcnt[i]) < lat[i]) begin
        mcnt[i] <= mcnt[i] + 16'd1;
      end
    end
  end

  assign cpu_done[0] = (lat[0] != 0) && (int'(mcnt[0]) == lat[0]);
  assign cpu_done[1] = (lat[1] != 0) && (int'(mcnt[1]) == lat[1]);

  always @(negedge clk) begin
    if (out_valid[0] && out_ready[0]) got_q.push_back(out_result[0]);
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_job(input int i, input logic [15:0] a,
                          input logic [15:0] b);
    int n;
    n = 0;
    in_valid[i] = 1'b1;
    in_a[i] = a;
    in_b[i] = b;
    while (!in_ready[i] && n < 500) begin
      step();
      n++;
    end
    if (!in_ready[i]) check("push_tmo", 32'(in_ready[i]), 32'd1);
    step();
    in_valid[i] = 1'b0;
  endtask

  task automatic wait_valid(input int i, input int budget, output int n);
    n = 0;
    while (!out_valid[i] && n < budget) begin
      step();
      n++;
    end
    if (!out_valid[i]) check("wait_tmo", 32'(out_valid[i]), 32'd1);
  endtask

  task automatic take(input int i);
    out_ready[i] = 1'b1;
    step();
    out_ready[i] = 1'b0;
  endtask

  task automatic wait_got(input int want, input int budget);
    int n;
    n = 0;
    while (got_q.size() < want && n < budget) begin
      step();
      n++;
    end
    check("got_cnt", 32'(got_q.size()), 32'(want));
  endtask

  int n;
  int stall_at;
  int acc;
  int errs;
  logic [15:0] ea [6];
  logic [15:0] eb [6];

  initial begin
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0;
      in_a[i] = '0;
      in_b[i] = '0;
      out_ready[i] = 1'b0;
      lat[i] = 7;
    end
    repeat (3) step();
    check("rst_in_ready", 32'(in_ready[0]), 32'd1);
    check("rst_busy", 32'(busy[0]), 32'd0);
    check("rst_out_valid", 32'(out_valid[0]), 32'd0);
    check("rst_jobs", 32'(jobs_done[0]), 32'd0);
    check("rst_start", 32'(cpu_start[0]), 32'd0);
    rst_n = 1'b1;
    step();

    // 1: single job, done on 7th WAIT cycle
    in_valid[0] = 1'b1;
    in_a[0] = 16'd5;
    in_b[0] = 16'd3;
    step();
    in_valid[0] = 1'b0;
    check("t1_start_t1", 32'(cpu_start[0]), 32'd0);
    step();
    check("t1_start_t2", 32'(cpu_start[0]), 32'd1);
    check("t1_op_a", 32'(cpu_operand_a[0]), 32'd5);
    check("t1_op_b", 32'(cpu_operand_b[0]), 32'd3);
    step();
    check("t1_start_off", 32'(cpu_start[0]), 32'd0);
    n = 1;
    while (!out_valid[0] && n < 100) begin
      step();
      n++;
    end
    check("t1_latency", 32'(n), 32'd8);
    check("t1_result", 32'(out_result[0]), 32'd8);
    check("t1_timeout", 32'(out_timeout[0]), 32'd0);
    check("t1_cycles", 32'(out_cycles[0]), 32'd7);
    check("t1_op_hold", 32'(cpu_operand_a[0]), 32'd5);
    take(0);
    check("t1_valid_off", 32'(out_valid[0]), 32'd0);
    check("t1_jobs", 32'(jobs_done[0]), 32'd1);

    // 2: six jobs back-to-back, latency 20
    lat[0] = 20;
    got_q.delete();
    out_ready[0] = 1'b1;
    stall_at = -1;
    for (int j = 0; j < 6; j++) begin
      ea[j] = 16'(100 * j + 1);
      eb[j] = 16'(j + 7);
      if (!in_ready[0] && stall_at < 0) stall_at = j;
      push_job(0, ea[j], eb[j]);
    end
    check("t2_stall_at", 32'(stall_at), 32'd5);
    wait_got(6, 400);
    for (int j = 0; j < 6; j++) begin
      if (j < got_q.size())
        check("t2_order", 32'(got_q[j]), 32'(ea[j] + eb[j]));
    end
    out_ready[0] = 1'b0;

    // 4: backpressure for 10 cycles
    lat[0] = 3;
    push_job(0, 16'd10, 16'd20);
    wait_valid(0, 50, n);
    acc = 0;
    errs = 0;
    for (int j = 0; j < 10; j++) begin
      in_valid[0] = 1'b1;
      in_a[0] = 16'(acc + 1);
      in_b[0] = 16'd100;
      if (in_ready[0]) acc++;
      step();
      if (!out_valid[0] || out_result[0] != 16'd30 ||
          out_cycles[0] != 16'd3 || cpu_start[0])
        errs++;
    end
    in_valid[0] = 1'b0;
    check("t4_stable", 32'(errs), 32'd0);
    check("t4_accepted", 32'(acc), 32'd4);
    check("t4_full", 32'(in_ready[0]), 32'd0);
    got_q.delete();
    out_ready[0] = 1'b1;
    wait_got(5, 200);
    if (got_q.size() == 5) begin
      check("t4_r0", 32'(got_q[0]), 32'd30);
      check("t4_r1", 32'(got_q[1]), 32'd101);
      check("t4_r4", 32'(got_q[4]), 32'd104);
    end
    out_ready[0] = 1'b0;
    repeat (3) step();
    check("t4_idle", 32'(busy[0]), 32'd0);
    check("t4_jobs", 32'(jobs_done[0]), 32'd12);

    // 3: timeout 16 with done tied low, next job still runs
    lat[1] = 0;
    push_job(1, 16'd1, 16'd1);
    push_job(1, 16'd2, 16'd2);
    wait_valid(1, 100, n);
    check("t3_timeout", 32'(out_timeout[1]), 32'd1);
    check("t3_result", 32'(out_result[1]), 32'd0);
    check("t3_cycles", 32'(out_cycles[1]), 32'd16);
    take(1);
    check("t3_gap_start", 32'(cpu_start[1]), 32'd0);
    step();
    check("t3_next_start", 32'(cpu_start[1]), 32'd1);
    check("t3_next_op", 32'(cpu_operand_a[1]), 32'd2);
    wait_valid(1, 100, n);
    check("t3_timeout2", 32'(out_timeout[1]), 32'd1);
    take(1);

    // 5: done on the 16th WAIT cycle beats timeout
    lat[1] = 16;
    push_job(1, 16'h1000, 16'h0234);
    wait_valid(1, 100, n);
    check("t5_timeout", 32'(out_timeout[1]), 32'd0);
    check("t5_result", 32'(out_result[1]), 32'h1234);
    check("t5_cycles", 32'(out_cycles[1]), 32'd16);
    take(1);
    check("t5_jobs", 32'(jobs_done[1]), 32'd3);

    // 6: reset mid-WAIT with 3 jobs queued
    lat[0] = 50;
    for (int j = 0; j < 4; j++) push_job(0, 16'(j), 16'd1);
    repeat (10) step();
    check("t6_busy_pre", 32'(busy[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_start", 32'(cpu_start[0]), 32'd0);
    check("t6_op_a", 32'(cpu_operand_a[0]), 32'd0);
    check("t6_valid", 32'(out_valid[0]), 32'd0);
    check("t6_jobs", 32'(jobs_done[0]), 32'd0);
    check("t6_busy", 32'(busy[0]), 32'd0);
    check("t6_in_ready", 32'(in_ready[0]), 32'd1);
    step();
    rst_n = 1'b1;
    lat[0] = 4;
    step();
    push_job(0, 16'd2, 16'd2);
    wait_valid(0, 50, n);
    check("t6_result", 32'(out_result[0]), 32'd4);
    check("t6_cycles", 32'(out_cycles[0]), 32'd4);
    take(0);
    check("t6_jobs_after", 32'(jobs_done[0]), 32'd1);
    check("t6_idle", 32'(busy[0]), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
